// File: rtl/apb3_pkg.sv
// Shared types for the APB3 master bridge: FSM state encoding and the
// response record handed back on the rsp stream.
package apb3_pkg;

  localparam int APB3_DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb3_mst_state_e;

  typedef struct packed {
    logic [APB3_DEF_DW-1:0] rdata;
    logic                   err;
    logic                   timeout;
  } apb3_rsp_t;

endpackage

// File: rtl/apb3_timeout_cnt.sv
// Counts consecutive ACCESS cycles without pready and flags the cycle in
// which the budget runs out; TIMEOUT_CYCLES=0 means never expire.
module apb3_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  // Keep the counter at least one bit wide so the disabled case still elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Fires during the Nth stalled cycle, i.e. when N-1 stalls were already counted.
  assign expired = (TIMEOUT_CYCLES != 0) && inc && (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/apb3_master_bridge.sv
// Turns a valid/ready command stream into single APB3 transfers and returns
// each result (data, slave error, timeout abort) on a valid/ready response stream.
module apb3_master_bridge
  import apb3_pkg::*;
#(
  parameter int APB_AW         = 20,
  parameter int APB_DW         = APB3_DEF_DW,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [APB_AW-1:0] cmd_addr,
  input  logic [APB_DW-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [APB_AW-1:0] m_apb3_paddr,
  output logic              m_apb3_psel,
  output logic              m_apb3_penable,
  output logic              m_apb3_pwrite,
  output logic [APB_DW-1:0] m_apb3_pwdata,
  input  logic              m_apb3_pready,
  input  logic [APB_DW-1:0] m_apb3_prdata,
  input  logic              m_apb3_pslverror
);

  apb3_mst_state_e state;
  apb3_rsp_t       rsp_q;
  logic            timeout_hit;

  apb3_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == SETUP),
    .inc    ((state == ACCESS) && !m_apb3_pready),
    .expired(timeout_hit)
  );

  // NOTE: every register here is updated with <= so all next-state terms read
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_q          <= '0;
      m_apb3_paddr   <= '0;
      m_apb3_psel    <= 1'b0;
      m_apb3_penable <= 1'b0;
      m_apb3_pwrite  <= 1'b0;
      m_apb3_pwdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ready && cmd_valid) begin
            m_apb3_paddr  <= cmd_addr;
            m_apb3_pwrite <= cmd_write;
            m_apb3_pwdata <= cmd_wdata;
            m_apb3_psel   <= 1'b1;
            cmd_ready     <= 1'b0;
            state         <= SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          m_apb3_penable <= 1'b1;
          state          <= ACCESS;
        end
        ACCESS: begin
          // A ready slave wins over an expiring budget in the same cycle.
          if (m_apb3_pready) begin
            rsp_q.rdata    <= m_apb3_pwrite ? '0 : APB3_DEF_DW'(m_apb3_prdata);
            rsp_q.err      <= m_apb3_pslverror;
            rsp_q.timeout  <= 1'b0;
            m_apb3_psel    <= 1'b0;
            m_apb3_penable <= 1'b0;
            rsp_valid      <= 1'b1;
            state          <= RESP;
          end else if (timeout_hit) begin
            rsp_q.rdata    <= '0;
            rsp_q.err      <= 1'b1;
            rsp_q.timeout  <= 1'b1;
            m_apb3_psel    <= 1'b0;
            m_apb3_penable <= 1'b0;
            rsp_valid      <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_rdata   = APB_DW'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Directed bench for apb3_master_bridge with a short timeout budget of 4 cycles.
module tb_apb3_master_bridge;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite, pready, pslverror;
  logic [DW-1:0] pwdata, prdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb3_master_bridge #(
    .APB_AW(AW),
    .APB_DW(DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .rsp_timeout     (rsp_timeout),
    .m_apb3_paddr    (paddr),
    .m_apb3_psel     (psel),
    .m_apb3_penable  (penable),
    .m_apb3_pwrite   (pwrite),
    .m_apb3_pwdata   (pwdata),
    .m_apb3_pready   (pready),
    .m_apb3_prdata   (prdata),
    .m_apb3_pslverror(pslverror)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "simulation watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; pready = 1'b0; prdata = '0; pslverror = 1'b0;
    tick(); tick();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_paddr", paddr, 0);
    rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Write, zero-wait slave; pready held high everywhere, prdata junk.
    drive_cmd(1'b1, 20'h00C04, 32'hDEADBEEF);
    pready = 1'b1; prdata = 32'hFFFF_FFFF;
    tick();
    cmd_valid = 1'b0;
    check("wr_c1_psel", psel, 1);
    check("wr_c1_penable", penable, 0);
    check("wr_c1_paddr", paddr, 32'h00C04);
    check("wr_c1_pwdata", pwdata, 32'hDEADBEEF);
    check("wr_c1_pwrite", pwrite, 1);
    check("wr_c1_cmd_ready", cmd_ready, 0);
    tick();
    check("wr_c2_psel", psel, 1);
    check("wr_c2_penable", penable, 1);
    check("wr_c2_paddr", paddr, 32'h00C04);
    check("wr_c2_pwdata", pwdata, 32'hDEADBEEF);
    check("wr_c2_rsp_valid", rsp_valid, 0);
    tick();
    check("wr_c3_rsp_valid", rsp_valid, 1);
    check("wr_c3_err", rsp_err, 0);
    check("wr_c3_rdata", rsp_rdata, 0);
    check("wr_c3_timeout", rsp_timeout, 0);
    check("wr_c3_psel", psel, 0);
    check("wr_c3_penable", penable, 0);
    tick();
    check("wr_c4_rsp_valid", rsp_valid, 0);
    check("wr_c4_cmd_ready", cmd_ready, 1);

    // Read with three wait states; pslverror/prdata junk while pready low.
    drive_cmd(1'b0, 20'h00404, 32'h0);
    pready = 1'b0; pslverror = 1'b1; prdata = 32'hAAAA_AAAA;
    tick();
    cmd_valid = 1'b0;
    check("rd_c1_paddr", paddr, 32'h00404);
    check("rd_c1_pwrite", pwrite, 0);
    tick(); tick(); tick();
    check("rd_c4_penable", penable, 1);
    check("rd_c4_rsp_valid", rsp_valid, 0);
    tick();
    check("rd_c5_penable", penable, 1);
    pready = 1'b1; pslverror = 1'b0; prdata = 32'h12345678;
    tick();
    pready = 1'b0;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rdata", rsp_rdata, 32'h12345678);
    check("rd_err", rsp_err, 0);
    check("rd_psel", psel, 0);
    tick();
    check("rd_idle_cmd_ready", cmd_ready, 1);

    // Read answered with a slave error.
    drive_cmd(1'b0, 20'h00008, 32'h0);
    pready = 1'b1; pslverror = 1'b1; prdata = 32'h0BADF00D;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    check("slverr_rsp_valid", rsp_valid, 1);
    check("slverr_err", rsp_err, 1);
    check("slverr_timeout", rsp_timeout, 0);
    check("slverr_rdata", rsp_rdata, 32'h0BADF00D);
    pslverror = 1'b0;
    tick();
    check("slverr_next_cmd_ready", cmd_ready, 1);

    // Timeout: pready never asserted across four ACCESS cycles.
    drive_cmd(1'b0, 20'h00100, 32'h0);
    pready = 1'b0; prdata = 32'h5555_5555;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("to_c5_penable", penable, 1);
    check("to_c5_rsp_valid", rsp_valid, 0);
    tick();
    check("to_psel", psel, 0);
    check("to_penable", penable, 0);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_err", rsp_err, 1);
    check("to_timeout", rsp_timeout, 1);
    check("to_rdata", rsp_rdata, 0);
    tick();

    // pready on the 4th ACCESS cycle completes normally.
    drive_cmd(1'b0, 20'h00104, 32'h0);
    pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick(); tick();
    pready = 1'b1; prdata = 32'h55AA55AA;
    tick();
    pready = 1'b0;
    check("to4_rsp_valid", rsp_valid, 1);
    check("to4_err", rsp_err, 0);
    check("to4_timeout", rsp_timeout, 0);
    check("to4_rdata", rsp_rdata, 32'h55AA55AA);
    tick();

    // Backpressure: response stalled ten cycles while a second command waits.
    rsp_ready = 1'b0;
    drive_cmd(1'b1, 20'h00200, 32'h11111111);
    pready = 1'b1;
    tick();
    drive_cmd(1'b1, 20'h00300, 32'h22222222);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_psel", psel, 0);
      check("bp_paddr", paddr, 32'h00200);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_rsp_valid", rsp_valid, 0);
    check("bp_release_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("bp_second_psel", psel, 1);
    check("bp_second_paddr", paddr, 32'h00300);
    check("bp_second_pwdata", pwdata, 32'h22222222);
    tick(); tick();
    check("bp_second_rsp_valid", rsp_valid, 1);
    tick();
    check("bp_second_done", rsp_valid, 0);

    // Reset during ACCESS, then a clean transaction.
    drive_cmd(1'b0, 20'h00404, 32'h0);
    pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mid_rst_in_access", penable, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_psel", psel, 0);
    check("mid_rst_penable", penable, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    tick();
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_no_rsp", rsp_valid, 0);
    drive_cmd(1'b1, 20'h00C08, 32'hCAFEF00D);
    pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("after_rst_paddr", paddr, 32'h00C08);
    tick(); tick();
    check("after_rst_rsp_valid", rsp_valid, 1);
    check("after_rst_err", rsp_err, 0);
    tick();
    check("after_rst_idle", cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
